// File: rtl/pad_in_filter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pad_in_filter_pkg : shared widths and limits for pad_in_filter   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package pad_in_filter_pkg;

   localparam int c_edge_cnt_w = 16;

   typedef logic [c_edge_cnt_w-1:0] edge_cnt_t;

   localparam edge_cnt_t c_edge_cnt_max = '1;

endpackage
`default_nettype wire

// File: rtl/prim_flop_2sync.sv
`default_nettype none
// +------------------------------------------------------------------+
// | prim_flop_2sync : two-flop synchronizer with configurable reset  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module prim_flop_2sync #(
   parameter logic ResetValue = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic r_s1;
   logic r_s2;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_s1 <= ResetValue;
         r_s2 <= ResetValue;
      end else begin
         r_s1 <= d_i;
         r_s2 <= r_s1;
      end
   end

   assign q_o = r_s2;

endmodule
`default_nettype wire

// File: rtl/pad_in_filter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pad_in_filter : synchronizing debounce filter with edge counter  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module pad_in_filter
   import pad_in_filter_pkg::*;
#(
   parameter int   CntW       = 8,
   parameter logic ResetValue = 1'b0
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    pad_i,
   input  logic                    enable_i,
   input  logic                    filter_en_i,
   input  logic [CntW-1:0]         thresh_i,
   input  logic                    cnt_clr_i,
   output logic                    in_o,
   output logic                    rise_o,
   output logic                    fall_o,
   output logic [c_edge_cnt_w-1:0] edge_cnt_o
);

   logic            w_s2;
   logic [CntW-1:0] w_thr_m1;
   logic            w_diff;
   logic            w_count;
   logic            w_load;

   logic [CntW-1:0] r_cnt;
   logic            r_in;
   logic            r_rise;
   logic            r_fall;
   edge_cnt_t       r_edge_cnt;

   prim_flop_2sync #(
      .ResetValue (ResetValue)
   ) u_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (pad_i),
      .q_o    (w_s2)
   );

   // A zero threshold is folded onto one so both need a single stable cycle
   assign w_thr_m1 = (thresh_i == '0) ? '0 : (thresh_i - CntW'(1));
   assign w_diff   = w_s2 ^ r_in;
   assign w_count  = enable_i & filter_en_i & w_diff;
   assign w_load   = enable_i & w_diff & (~filter_en_i | (r_cnt >= w_thr_m1));

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_cnt <= '0;
      end else if (w_count && !w_load) begin
         r_cnt <= r_cnt + CntW'(1);
      end else begin
         r_cnt <= '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_in   <= ResetValue;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_rise <= w_load & w_s2;
         r_fall <= w_load & ~w_s2;
         if (w_load) begin
            r_in <= w_s2;
         end
      end
   end

   // Clear has priority over a coincident edge; the count sticks at its maximum
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_edge_cnt <= '0;
      end else if (cnt_clr_i) begin
         r_edge_cnt <= '0;
      end else if (w_load && (r_edge_cnt != c_edge_cnt_max)) begin
         r_edge_cnt <= r_edge_cnt + edge_cnt_t'(1);
      end
   end

   assign in_o       = r_in;
   assign rise_o     = r_rise;
   assign fall_o     = r_fall;
   assign edge_cnt_o = r_edge_cnt;

endmodule
`default_nettype wire
